// File: rtl/uart_cmd_parser.sv
// Parses SYNC/ADDR/DATA/CHK byte frames from a UART receiver into register-write strobes.
// Frames with a bad checksum or an over-long inter-byte gap are dropped with a one-cycle error strobe.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE        = 8'hA5,
    parameter int         CLKS_PER_TIMEOUT = 4160
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_Data_Valid,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Wr_Valid,
    output logic [7:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Chk_Err,
    output logic       o_Timeout_Err,
    output logic       o_Busy
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(CLKS_PER_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_CHK
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_count, w_count_next;
    logic [7:0]  r_addr, w_addr_next;
    logic [7:0]  r_data, w_data_next;
    logic [7:0]  r_wr_addr, w_wr_addr_next;
    logic [7:0]  r_wr_data, w_wr_data_next;
    logic        r_wr_valid, w_wr_valid_next;
    logic        r_chk_err, w_chk_err_next;
    logic        r_timeout_err, w_timeout_err_next;
    logic        w_timeout;
    logic [7:0]  w_sum;

    // A byte strobe on the limit cycle takes priority over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !i_RX_Data_Valid && (r_count == TIMEOUT_LAST);
    assign w_sum     = r_addr + r_data;

    always_comb begin
        w_state_next       = r_state;
        w_addr_next        = r_addr;
        w_data_next        = r_data;
        w_wr_addr_next     = r_wr_addr;
        w_wr_data_next     = r_wr_data;
        w_wr_valid_next    = 1'b0;
        w_chk_err_next     = 1'b0;
        w_timeout_err_next = 1'b0;
        w_count_next       = (i_RX_Data_Valid || (r_state == S_IDLE)) ? 16'd0 : r_count + 16'd1;

        if (w_timeout) begin
            w_state_next       = S_IDLE;
            w_timeout_err_next = 1'b1;
        end else if (i_RX_Data_Valid) begin
            case (r_state)
                S_IDLE: begin
                    if (i_RX_Byte == SYNC_BYTE) begin
                        w_state_next = S_GET_ADDR;
                    end
                end
                S_GET_ADDR: begin
                    w_addr_next  = i_RX_Byte;
                    w_state_next = S_GET_DATA;
                end
                S_GET_DATA: begin
                    w_data_next  = i_RX_Byte;
                    w_state_next = S_GET_CHK;
                end
                S_GET_CHK: begin
                    w_state_next = S_IDLE;
                    if (i_RX_Byte == w_sum) begin
                        w_wr_valid_next = 1'b1;
                        w_wr_addr_next  = r_addr;
                        w_wr_data_next  = r_data;
                    end else begin
                        w_chk_err_next = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state       <= S_IDLE;
            r_count       <= 16'd0;
            r_addr        <= 8'd0;
            r_data        <= 8'd0;
            r_wr_addr     <= 8'd0;
            r_wr_data     <= 8'd0;
            r_wr_valid    <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_addr        <= w_addr_next;
            r_data        <= w_data_next;
            r_wr_addr     <= w_wr_addr_next;
            r_wr_data     <= w_wr_data_next;
            r_wr_valid    <= w_wr_valid_next;
            r_chk_err     <= w_chk_err_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    assign o_Wr_Valid    = r_wr_valid;
    assign o_Wr_Addr     = r_wr_addr;
    assign o_Wr_Data     = r_wr_data;
    assign o_Chk_Err     = r_chk_err;
    assign o_Timeout_Err = r_timeout_err;
    assign o_Busy        = (r_state != S_IDLE);

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the frame start marker.
REQ-002 The block SHALL have parameter CLKS_PER_TIMEOUT, default 4160, the inter-byte timeout in clocks (two byte times at 208 clocks/bit); legal range is 2..65535.
REQ-003 i_Clock  input  1  the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 i_Reset  input  1  reset, asynchronous and active-high.
REQ-005 i_RX_Data_Valid  input  1  one-cycle strobe marking a received byte from the upstream UART receiver.
REQ-006 i_RX_Byte  input  8  received byte, valid only when i_RX_Data_Valid=1.
REQ-007 o_Wr_Valid  output  1  one-cycle register-write strobe.
REQ-008 o_Wr_Addr  output  8  write address.
REQ-009 o_Wr_Data  output  8  write data.
REQ-010 o_Chk_Err  output  1  one-cycle strobe for a checksum mismatch.
REQ-011 o_Timeout_Err  output  1  one-cycle strobe for an inter-byte timeout.
REQ-012 o_Busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 A frame SHALL be 4 bytes in order: SYNC_BYTE, ADDR, DATA, CHK, where a good frame has CHK = (ADDR + DATA) mod 256.
REQ-014 The FSM SHALL have states IDLE, GET_ADDR, GET_DATA, GET_CHK and SHALL advance only on cycles with i_RX_Data_Valid=1, except on timeout.
REQ-015 IDLE: a byte equal to SYNC_BYTE SHALL go to GET_ADDR; any other byte SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-016 GET_ADDR: the byte SHALL be latched as the address and the FSM SHALL go to GET_DATA; a byte equal to SYNC_BYTE SHALL be taken as the address (no resync).
REQ-017 GET_DATA: the byte SHALL be latched as the data and the FSM SHALL go to GET_CHK.
REQ-018 GET_CHK: the sum SHALL be computed as an 8-bit sum with carry discarded, and the FSM SHALL return to IDLE in the cycle after the CHK byte regardless of the compare result.
REQ-019 On a match, o_Wr_Valid SHALL be high for exactly the one cycle after the CHK strobe cycle, and o_Wr_Addr/o_Wr_Data SHALL take the frame values in that same cycle.
REQ-020 On a mismatch, o_Chk_Err SHALL pulse for one cycle with the same latency, and o_Wr_Addr/o_Wr_Data SHALL stay unchanged.
REQ-021 o_Wr_Addr/o_Wr_Data SHALL hold their values until the next good frame; internal ADDR/DATA latches SHALL NOT drive the outputs directly.
REQ-022 Timeout counter: 16 bits; it SHALL clear to 0 on every i_RX_Data_Valid cycle and in IDLE, and SHALL increment by 1 per clock in any other state.
REQ-023 When the counter equals CLKS_PER_TIMEOUT-1 in a non-IDLE state with no byte strobe, the FSM SHALL go to IDLE, o_Timeout_Err SHALL pulse one cycle later, and the partial frame SHALL be dropped.
REQ-024 If a byte strobe arrives in the same cycle the counter reaches its limit, the byte SHALL win, the counter SHALL clear, and no timeout SHALL occur.
REQ-025 A byte arriving in the cycle the FSM returns to IDLE after a frame or timeout SHALL be evaluated under the IDLE rules, so back-to-back frames SHALL be accepted.
REQ-026 o_Wr_Valid, o_Chk_Err and o_Timeout_Err SHALL be mutually exclusive in any cycle.
REQ-027 i_RX_Byte SHALL be ignored whenever i_RX_Data_Valid=0.

Reset
REQ-028 While i_Reset=1 (asserted asynchronously), the state SHALL be IDLE, the counter 0, internal latches 0, and all outputs 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no error or write strobe; the first frame after release SHALL be parsed normally.

Verification
REQ-030 Bytes A5,10,22,32 -> o_Wr_Valid=1 one cycle after the CHK strobe, o_Wr_Addr=8'h10, o_Wr_Data=8'h22, no error pulses.
REQ-031 Bytes A5,F0,20,10 (wraps) -> write to 8'hF0 with data 8'h20; then A5,01,02,04 -> o_Chk_Err pulse, outputs still F0/20.
REQ-032 Bytes 00,FF,A5,A5,01,A6 -> leading 00,FF ignored; write to addr 8'hA5 with data 8'h01.
REQ-033 A5,10 then idle for 4160 clocks -> o_Timeout_Err pulses once, o_Busy=0; with the gap at 4159 clocks before the next byte, no timeout occurs.
REQ-034 Reset pulse after A5,10,22 -> no strobes; the following A5,33,44,77 -> write 33/44.
REQ-035 Two good frames back-to-back with a byte strobe every 2 clocks -> two o_Wr_Valid pulses, both with correct addr/data.
